// File: rtl/instr_fetch.sv
// Program-counter and fetch sequencer feeding the control decoder.
// Runs an IDLE/RUN/DONE program handshake and counts executed RUN cycles.
module instr_fetch #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned END_ADDR   = 2**PC_W - 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Branch,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Target,
    input  logic             HaltReq,
    output logic [PC_W-1:0]  PC,
    output logic             InstrValid,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    localparam logic [PC_W-1:0] L_START = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] L_END   = PC_W'(END_ADDR);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_instr_valid;
    logic             r_done;

    logic             w_halt;
    logic             w_take_branch;
    logic [PC_W-1:0]  w_pc_inc;
    logic [CNT_W-1:0] w_cnt_next;

    // The END_ADDR instruction still executes, then the program ends.
    assign w_halt        = HaltReq || (r_pc == L_END);
    assign w_take_branch = Branch && Taken;
    assign w_pc_inc      = r_pc + PC_W'(1);
    assign w_cnt_next    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state       <= StIdle;
            r_pc          <= L_START;
            r_cnt         <= '0;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (Start) begin
                        r_state       <= StRun;
                        r_pc          <= L_START;
                        r_cnt         <= '0;
                        r_instr_valid <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                StRun: begin
                    r_cnt <= w_cnt_next;
                    if (w_halt) begin
                        r_state       <= StDone;
                        r_instr_valid <= 1'b0;
                        r_done        <= 1'b1;
                    end else if (w_take_branch) begin
                        r_pc <= Target;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                default: begin
                    r_state       <= StIdle;
                    r_pc          <= L_START;
                    r_cnt         <= '0;
                    r_instr_valid <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    assign PC         = r_pc;
    assign InstrValid = r_instr_valid;
    assign Done       = r_done;
    assign CycleCount = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: three instances with different parameters share the
// stimulus; each scenario checks only the instance it targets.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       branch;
    logic       taken;
    logic [9:0] target;
    logic       halt_req;

    logic [9:0]  a_pc;
    logic        a_valid, a_done;
    logic [15:0] a_cnt;
    logic [9:0]  b_pc;
    logic        b_valid, b_done;
    logic [15:0] b_cnt;
    logic [2:0]  c_pc;
    logic        c_valid, c_done;
    logic [3:0]  c_cnt;
    logic [2:0]  c_target;

    int n_cmp = 0;
    int n_err = 0;

    assign c_target = target[2:0];

    always #5 clk = ~clk;

    instr_fetch u_a (
        .CLK(clk), .Reset(reset), .Start(start), .Branch(branch), .Taken(taken),
        .Target(target), .HaltReq(halt_req), .PC(a_pc), .InstrValid(a_valid),
        .Done(a_done), .CycleCount(a_cnt)
    );

    instr_fetch #(.END_ADDR(7)) u_b (
        .CLK(clk), .Reset(reset), .Start(start), .Branch(branch), .Taken(taken),
        .Target(target), .HaltReq(halt_req), .PC(b_pc), .InstrValid(b_valid),
        .Done(b_done), .CycleCount(b_cnt)
    );

    instr_fetch #(.PC_W(3), .CNT_W(4), .END_ADDR(5)) u_c (
        .CLK(clk), .Reset(reset), .Start(start), .Branch(branch), .Taken(taken),
        .Target(c_target), .HaltReq(halt_req), .PC(c_pc), .InstrValid(c_valid),
        .Done(c_done), .CycleCount(c_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        branch   = 1'b0;
        taken    = 1'b0;
        target   = '0;
        halt_req = 1'b0;
    endtask

    task automatic reset_and_start();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        check("rst_pc", a_pc, 0);
        check("rst_valid", a_valid, 0);
        check("rst_done", a_done, 0);
        check("rst_cnt", a_cnt, 0);

        // IDLE ignores branch/halt.
        reset    = 1'b0;
        branch   = 1'b1;
        taken    = 1'b1;
        target   = 10'd20;
        halt_req = 1'b1;
        tick();
        check("idle_pc", a_pc, 0);
        check("idle_valid", a_valid, 0);
        check("idle_done", a_done, 0);
        idle_inputs();

        // Straight-line fetch, then branch taken / not taken.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run0_pc", a_pc, 0);
        check("run0_valid", a_valid, 1);
        check("run0_cnt", a_cnt, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("seq_pc", a_pc, k);
            check("seq_cnt", a_cnt, k);
            check("seq_valid", a_valid, 1);
        end
        branch = 1'b1;
        taken  = 1'b1;
        target = 10'd20;
        tick();
        check("br_taken_pc", a_pc, 20);
        check("br_taken_cnt", a_cnt, 6);
        taken = 1'b0;
        tick();
        check("br_nt_pc", a_pc, 21);
        idle_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_run_pc", a_pc, 22);
        check("start_in_run_cnt", a_cnt, 8);

        // Halt beats branch at PC=3.
        reset_and_start();
        tick(3);
        check("halt_pre_pc", a_pc, 3);
        halt_req = 1'b1;
        branch   = 1'b1;
        taken    = 1'b1;
        target   = 10'd20;
        check("halt_cycle_valid", a_valid, 1);
        tick();
        idle_inputs();
        check("halt_done", a_done, 1);
        check("halt_valid", a_valid, 0);
        check("halt_pc", a_pc, 3);
        check("halt_cnt", a_cnt, 4);
        tick();
        check("done_hold_pc", a_pc, 3);
        check("done_hold_cnt", a_cnt, 4);
        check("done_hold_done", a_done, 1);

        // END_ADDR=7 straight-line run, then restart from DONE.
        reset_and_start();
        tick(7);
        check("end_pc", b_pc, 7);
        check("end_valid", b_valid, 1);
        check("end_done_pre", b_done, 0);
        tick();
        check("end_done", b_done, 1);
        check("end_valid_post", b_valid, 0);
        check("end_hold_pc", b_pc, 7);
        check("end_cnt", b_cnt, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_pc", b_pc, 0);
        check("restart_cnt", b_cnt, 0);
        check("restart_valid", b_valid, 1);
        check("restart_done", b_done, 0);

        // Reset mid-RUN at PC=9, with Start held during the reset cycle.
        reset_and_start();
        tick(9);
        check("mid_pc", a_pc, 9);
        reset = 1'b1;
        start = 1'b1;
        tick();
        check("midrst_pc", a_pc, 0);
        check("midrst_valid", a_valid, 0);
        check("midrst_cnt", a_cnt, 0);
        check("midrst_done", a_done, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("midrst_stay_idle", a_valid, 0);

        // Small instance: self-loop saturates the 4-bit counter, then PC wraps 7->0.
        reset_and_start();
        branch = 1'b1;
        taken  = 1'b1;
        target = 10'd0;
        tick(15);
        check("sat15_cnt", c_cnt, 15);
        tick(5);
        check("sat_cnt", c_cnt, 15);
        check("loop_pc", c_pc, 0);
        check("loop_valid", c_valid, 1);
        idle_inputs();
        tick(4);
        check("pre_skip_pc", c_pc, 4);
        branch = 1'b1;
        taken  = 1'b1;
        target = 10'd6;
        tick();
        idle_inputs();
        check("skip_pc", c_pc, 6);
        tick();
        check("pc7", c_pc, 7);
        tick();
        check("wrap_pc", c_pc, 0);
        check("wrap_valid", c_valid, 1);
        check("wrap_cnt", c_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
